lzw_seq_ctrl: RTL
=================

# lzw_seq_ctrl

Parametrised top-level sequencer for the LZW compressor. It replaces the single-shot controller with a multi-frame version that loops back after each frame. It drives code-RAM initialisation, serial receive into IO RAM, the LZW run, and word-by-word serial transmit from out RAM. It sits between the serial port, the two RAMs and `lzw_ctrl`, and adds empty-frame handling, a transmit timeout, abort and frame counting.

## Interface
- `ADDR_W`, 12, RAM address width; frame depth is DEPTH = 2^ADDR_W characters.
- `CHAR_W`, 8, received character width.
- `EOF_CODE`, 8'h0D, frame terminator, compared on `rcv_done` only.
- `XMT_TIMEOUT`, 1023, maximum cycles to wait for `xmt_done`; 0 disables the timeout.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rcv_done` in 1: character valid pulse. `char_in` in CHAR_W: character.
- `xmt_done` in 1: serial word sent.
- `done_cr` in 1, `lzw_done` in 1: completion inputs from `lzw_ctrl`.
- `outram_cnt` in ADDR_W: index of the last valid out-RAM word.
- `abort` in 1: synchronous abort of the current frame.
- `init_cr` out 1, `init_lzw` out 1: registered one-cycle starts.
- `char_cnt` out ADDR_W+1: characters stored in the current frame.
- `addra_ioram` out ADDR_W, `ena_ioram` out 1, `wea_ioram` out 1: IO RAM port A.
- `addra_outram` out ADDR_W, `ena_outram` out 1: out RAM port A.
- `start_xmt` out 1: one-cycle transmit request.
- `busy` out 1: high in every state except IDLE and INIT_CR.
- `frame_done` out 1: registered one-cycle pulse per completed frame.
- `frame_cnt` out 16: completed frames; wraps at 16'hFFFF to 0.
- `xmt_err` out 1: sticky timeout flag; cleared only by reset.

## Operation
- The FSM is one-hot with states IDLE, INIT_CR, RX_WAIT, RX_INC, LZW_RUN, TX_LOAD, TX_GO, TX_WAIT, FRAME_END.
- **IDLE**: raises the internal init_cr request, then goes to INIT_CR.
- **INIT_CR**: waits for `done_cr`, then goes to RX_WAIT.
- **RX_WAIT**, on `rcv_done`:
  - If `char_in`==EOF_CODE and char_cnt==0: go to FRAME_END (empty frame; no LZW run, no transmit).
  - If `char_in`==EOF_CODE otherwise: raise the init_lzw request and go to LZW_RUN. The EOF character is not stored.
  - Any other character: `ena_ioram`=`wea_ioram`=1 at `addra_ioram`=char_cnt[ADDR_W-1:0], then go to RX_INC.
- **RX_INC**: increments char_cnt.
  - If the new value equals DEPTH: raise the init_lzw request and go to LZW_RUN (full frame).
  - Otherwise: go to RX_WAIT.
- **LZW_RUN**: on `lzw_done`, clear the out-address counter and go to TX_LOAD.
- **TX_LOAD**: `ena_outram`=1, then go to TX_GO.
- **TX_GO**: `start_xmt`=1, clear the timer, then go to TX_WAIT.
- **TX_WAIT**:
  - On `xmt_done` with out-address==`outram_cnt`: go to FRAME_END.
  - On `xmt_done` otherwise: increment the out-address and go to TX_LOAD.
  - With no `xmt_done` and the timer==XMT_TIMEOUT (when non-zero): set `xmt_err` and go to FRAME_END.
- **FRAME_END**: pulse `frame_done`, increment `frame_cnt`, clear char_cnt, go to IDLE. The code RAM is re-initialised for every frame.
- `abort` in any state other than IDLE: next state is IDLE, both counters are cleared, and there is no `frame_done` pulse. `abort` has priority over every other input.
- `rcv_done` outside RX_WAIT is ignored.

## Timing
- Reset values: all outputs 0; state is IDLE.
- `init_cr` and `init_lzw` are high for exactly the cycle after the state that raised the request.
- RAM enables, `start_xmt` and `busy` are combinational decodes of the current state.
- `frame_done`, `frame_cnt` and `xmt_err` update on the clock edge leaving FRAME_END or TX_WAIT.
- Receive throughput is at most one character per 2 cycles; `rcv_done` pulses must be at least 2 cycles apart.
- Transmit takes at least 3 cycles per word. `start_xmt` is asserted exactly once per word.
- The timer is ADDR_W-independent, $clog2(XMT_TIMEOUT+1) bits wide, and saturates.
- A frame of n characters writes addresses 0..n-1.
- DEPTH characters with no EOF start LZW with char_cnt=DEPTH; no address wraps.

## Configuration
- `LZW_SEQ_DEBUG_EN` defined: adds six sticky outputs, all reset to 0 and cleared only by reset:
  - `pwr_up`: set on leaving IDLE the first time.
  - `ser_recv_done`: set on EOF or full frame.
  - `init_cr_out`, `done_cr_out`, `init_lzw_out`, `lzw_done_out`: set by the corresponding event.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- `lzw_pkg` holds the state index constants, the EOF_CODE default, and the frame-count width (16).
- Sub-module `lzw_xmt_timer` (clear, enable, expired output) holds the timeout counter. With XMT_TIMEOUT=0 it ties expired to 0.

## Test plan
- Reset, `done_cr` at cycle 5, chars 41,42,43 then 0D → IO RAM holds 41,42,43 at addresses 0..2; char_cnt=3; one `init_lzw` pulse; 0D is not written.
- `lzw_done` with `outram_cnt`=2 and `xmt_done` 4 cycles after each `start_xmt` → exactly 3 `start_xmt` pulses at out addresses 0,1,2; then `frame_done`, `frame_cnt`=1, `init_cr` pulses again.
- First character 0D → no `init_lzw`, no `start_xmt`; `frame_done` pulses and `frame_cnt` increments.
- ADDR_W=4, 16 non-EOF chars → `init_lzw` pulses after the 16th write; char_cnt=16.
- XMT_TIMEOUT=8, `xmt_done` held low → `xmt_err`=1 exactly 8 cycles after TX_WAIT entry, then `frame_done` pulses.
- `abort` during TX_WAIT → IDLE next cycle; `frame_cnt` unchanged; no `frame_done`.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared constants for the multi-frame LZW sequencer: one-hot state indices,
// the default frame terminator and the frame-count width.
package lzw_pkg;

  localparam int unsigned S_IDLE      = 0;
  localparam int unsigned S_INIT_CR   = 1;
  localparam int unsigned S_RX_WAIT   = 2;
  localparam int unsigned S_RX_INC    = 3;
  localparam int unsigned S_LZW_RUN   = 4;
  localparam int unsigned S_TX_LOAD   = 5;
  localparam int unsigned S_TX_GO     = 6;
  localparam int unsigned S_TX_WAIT   = 7;
  localparam int unsigned S_FRAME_END = 8;
  localparam int unsigned N_STATES    = 9;

  localparam logic [7:0] EOF_CODE_DEF = 8'h0D;
  localparam int unsigned FRAME_CNT_W = 16;

  // Each encoding sets exactly the bit named by the matching S_* index.
  typedef enum logic [N_STATES-1:0] {
    IDLE      = 9'h001,
    INIT_CR   = 9'h002,
    RX_WAIT   = 9'h004,
    RX_INC    = 9'h008,
    LZW_RUN   = 9'h010,
    TX_LOAD   = 9'h020,
    TX_GO     = 9'h040,
    TX_WAIT   = 9'h080,
    FRAME_END = 9'h100
  } seq_state_t;

  // Width needed to hold 0..limit; a disabled (zero) limit still gets one bit.
  function automatic int unsigned timer_w(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/lzw_xmt_timer.sv
// Saturating transmit-timeout counter; expired is high once the count reaches
// XMT_TIMEOUT. A zero XMT_TIMEOUT removes the counter and never expires.
module lzw_xmt_timer
  import lzw_pkg::*;
#(
  parameter int unsigned XMT_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = timer_w(XMT_TIMEOUT);

  generate
    if (XMT_TIMEOUT == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam logic [TW-1:0] LIMIT = TW'(XMT_TIMEOUT);
      logic [TW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (enable && (cnt_reg != LIMIT)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign expired = (cnt_reg == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/lzw_seq_ctrl.sv
// Multi-frame LZW sequencer: code-RAM init, serial receive, LZW run, word-wise
// transmit, then loop. Optional sticky debug outputs under LZW_SEQ_DEBUG_EN.
module lzw_seq_ctrl
  import lzw_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       CHAR_W      = 8,
  parameter logic [CHAR_W-1:0] EOF_CODE    = CHAR_W'(EOF_CODE_DEF),
  parameter int unsigned       XMT_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rcv_done,
  input  logic [CHAR_W-1:0]      char_in,
  input  logic                   xmt_done,
  input  logic                   done_cr,
  input  logic                   lzw_done,
  input  logic [ADDR_W-1:0]      outram_cnt,
  input  logic                   abort,
  output logic                   init_cr,
  output logic                   init_lzw,
  output logic [ADDR_W:0]        char_cnt,
  output logic [ADDR_W-1:0]      addra_ioram,
  output logic                   ena_ioram,
  output logic                   wea_ioram,
  output logic [ADDR_W-1:0]      addra_outram,
  output logic                   ena_outram,
  output logic                   start_xmt,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`ifdef LZW_SEQ_DEBUG_EN
  output logic                   xmt_err,
  output logic                   pwr_up,
  output logic                   ser_recv_done,
  output logic                   init_cr_out,
  output logic                   done_cr_out,
  output logic                   init_lzw_out,
  output logic                   lzw_done_out
`else
  output logic                   xmt_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t             state_reg, state_next;
  logic [ADDR_W:0]        char_cnt_reg, char_cnt_next, char_inc;
  logic [ADDR_W-1:0]      out_addr_reg, out_addr_next;
  logic                   init_cr_reg, init_cr_next;
  logic                   init_lzw_reg, init_lzw_next;
  logic                   frame_done_reg, frame_done_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   xmt_err_reg, xmt_err_next;
  logic                   is_eof;
  logic                   tmr_clear, tmr_enable, tmr_expired;

  assign char_inc = char_cnt_reg + 1'b1;
  assign is_eof   = (char_in == EOF_CODE);

  lzw_xmt_timer #(
    .XMT_TIMEOUT(XMT_TIMEOUT)
  ) u_xmt_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      char_cnt_reg   <= '0;
      out_addr_reg   <= '0;
      init_cr_reg    <= 1'b0;
      init_lzw_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      xmt_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      char_cnt_reg   <= char_cnt_next;
      out_addr_reg   <= out_addr_next;
      init_cr_reg    <= init_cr_next;
      init_lzw_reg   <= init_lzw_next;
      frame_done_reg <= frame_done_next;
      frame_cnt_reg  <= frame_cnt_next;
      xmt_err_reg    <= xmt_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    char_cnt_next   = char_cnt_reg;
    out_addr_next   = out_addr_reg;
    init_cr_next    = 1'b0;
    init_lzw_next   = 1'b0;
    frame_done_next = 1'b0;
    frame_cnt_next  = frame_cnt_reg;
    xmt_err_next    = xmt_err_reg;
    tmr_clear       = 1'b0;
    tmr_enable      = 1'b0;
    ena_ioram       = 1'b0;
    wea_ioram       = 1'b0;
    ena_outram      = 1'b0;
    start_xmt       = 1'b0;

    case (1'b1)
      state_reg[S_IDLE]: begin
        init_cr_next = 1'b1;
        state_next   = INIT_CR;
      end
      state_reg[S_INIT_CR]: begin
        if (done_cr) state_next = RX_WAIT;
      end
      state_reg[S_RX_WAIT]: begin
        if (rcv_done) begin
          if (is_eof && (char_cnt_reg == '0)) begin
            state_next = FRAME_END;
          end else if (is_eof) begin
            init_lzw_next = 1'b1;
            state_next    = LZW_RUN;
          end else begin
            ena_ioram  = 1'b1;
            wea_ioram  = 1'b1;
            state_next = RX_INC;
          end
        end
      end
      state_reg[S_RX_INC]: begin
        char_cnt_next = char_inc;
        if (char_inc == DEPTH_CNT) begin
          init_lzw_next = 1'b1;
          state_next    = LZW_RUN;
        end else begin
          state_next = RX_WAIT;
        end
      end
      state_reg[S_LZW_RUN]: begin
        if (lzw_done) begin
          out_addr_next = '0;
          state_next    = TX_LOAD;
        end
      end
      state_reg[S_TX_LOAD]: begin
        ena_outram = 1'b1;
        state_next = TX_GO;
      end
      state_reg[S_TX_GO]: begin
        start_xmt  = 1'b1;
        tmr_clear  = 1'b1;
        state_next = TX_WAIT;
      end
      state_reg[S_TX_WAIT]: begin
        tmr_enable = 1'b1;
        if (xmt_done) begin
          if (out_addr_reg == outram_cnt) begin
            state_next = FRAME_END;
          end else begin
            out_addr_next = out_addr_reg + 1'b1;
            state_next    = TX_LOAD;
          end
        end else if (tmr_expired) begin
          xmt_err_next = 1'b1;
          state_next   = FRAME_END;
        end
      end
      state_reg[S_FRAME_END]: begin
        frame_done_next = 1'b1;
        frame_cnt_next  = frame_cnt_reg + 1'b1;
        char_cnt_next   = '0;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides everything except the unconditional IDLE -> INIT_CR step.
    if (abort && !state_reg[S_IDLE]) begin
      state_next      = IDLE;
      char_cnt_next   = '0;
      out_addr_next   = '0;
      init_cr_next    = 1'b0;
      init_lzw_next   = 1'b0;
      frame_done_next = 1'b0;
      frame_cnt_next  = frame_cnt_reg;
      xmt_err_next    = xmt_err_reg;
      ena_ioram       = 1'b0;
      wea_ioram       = 1'b0;
    end
  end

  assign init_cr      = init_cr_reg;
  assign init_lzw     = init_lzw_reg;
  assign char_cnt     = char_cnt_reg;
  assign addra_ioram  = char_cnt_reg[ADDR_W-1:0];
  assign addra_outram = out_addr_reg;
  assign busy         = !(state_reg[S_IDLE] || state_reg[S_INIT_CR]);
  assign frame_done   = frame_done_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign xmt_err      = xmt_err_reg;

`ifdef LZW_SEQ_DEBUG_EN
  logic rx_end_ev;
  assign rx_end_ev = !abort &&
                     ((state_reg[S_RX_WAIT] && rcv_done && is_eof) ||
                      (state_reg[S_RX_INC] && (char_inc == DEPTH_CNT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_up        <= 1'b0;
      ser_recv_done <= 1'b0;
      init_cr_out   <= 1'b0;
      done_cr_out   <= 1'b0;
      init_lzw_out  <= 1'b0;
      lzw_done_out  <= 1'b0;
    end else begin
      if (state_reg[S_IDLE]) pwr_up <= 1'b1;
      if (rx_end_ev) ser_recv_done <= 1'b1;
      if (init_cr_reg) init_cr_out <= 1'b1;
      if (state_reg[S_INIT_CR] && done_cr) done_cr_out <= 1'b1;
      if (init_lzw_reg) init_lzw_out <= 1'b1;
      if (state_reg[S_LZW_RUN] && lzw_done) lzw_done_out <= 1'b1;
    end
  end
`endif

endmodule
